// File: rtl/pwm_driver.sv
// PWM output stage with a shadowed duty register and a per-period done strobe.
// The duty value is reloaded only on period wrap, so mid-period changes never cause runt pulses.
module pwm_driver #(
  parameter int N        = 8,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] duty,
  output logic         out,
  output logic         period_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         r_state, w_state_n;
  logic [N-1:0]   r_cnt, w_cnt_n;
  logic [N-1:0]   r_duty_q, w_duty_n;
  logic [PW-1:0]  r_pcnt, w_pcnt_n;
  logic           r_pd, w_pd_n;
  logic           w_step;
  logic           w_wrap;

  assign w_step = (r_state == RUN) && ena && (r_pcnt == PTOP);
  assign w_wrap = w_step && (r_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_pcnt   <= '0;
      r_duty_q <= '0;
      r_pd     <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_pcnt   <= w_pcnt_n;
      r_duty_q <= w_duty_n;
      r_pd     <= w_pd_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_pcnt_n  = r_pcnt;
    w_duty_n  = r_duty_q;
    w_pd_n    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_n  = '0;
        w_pcnt_n = '0;
        if (ena) begin
          w_state_n = RUN;
          w_duty_n  = duty;
        end
      end
      RUN: begin
        // Dropping ena takes priority over a coincident wrap: no strobe, no reload.
        if (!ena) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
          w_pcnt_n  = '0;
        end else if (w_step) begin
          w_pcnt_n = '0;
          w_cnt_n  = r_cnt + 1'b1;
          if (w_wrap) begin
            w_duty_n = duty;
            w_pd_n   = 1'b1;
          end
        end else begin
          w_pcnt_n = r_pcnt + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign out         = (r_state == RUN) && (r_cnt < r_duty_q);
  assign period_done = r_pd;

endmodule

// File: tb/tb_pwm_driver.sv
// Bench for pwm_driver: two instances (N=4, PRESCALE=2 and PRESCALE=1) checked every cycle
// against a time-based reference model, plus directed period-level checks.
module tb_pwm_driver;

  localparam int N  = 4;
  localparam int NS = 1 << N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena0 = 1'b0, ena1 = 1'b0;
  logic [N-1:0] duty0 = '0, duty1 = '0;
  logic         out0, out1, pd0, pd1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: cycles elapsed since RUN entry and the duty latched for the current period.
  bit          m_run [2];
  int unsigned m_t   [2];
  int unsigned m_dq  [2];

  bit loop_on = 1'b0;
  int tri_v   = 0;
  bit tri_up  = 1'b1;

  always #5 clk = ~clk;

  pwm_driver #(.N(N), .PRESCALE(2)) u_dut0 (
    .clk(clk), .rst(rst), .ena(ena0), .duty(duty0), .out(out0), .period_done(pd0)
  );

  pwm_driver #(.N(N), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .ena(ena1), .duty(duty1), .out(out1), .period_done(pd1)
  );

  function automatic int unsigned pre(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int unsigned plen(int i);
    return NS * pre(i);
  endfunction

  function automatic logic get_out(int i);
    return (i == 0) ? out0 : out1;
  endfunction

  function automatic logic get_pd(int i);
    return (i == 0) ? pd0 : pd1;
  endfunction

  function automatic logic exp_out(int i);
    return m_run[i] && ((m_t[i] % plen(i)) < m_dq[i] * pre(i));
  endfunction

  function automatic logic exp_pd(int i);
    return m_run[i] && (m_t[i] != 0) && ((m_t[i] % plen(i)) == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 1'b0;
      m_t[i]   = 0;
      m_dq[i]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic         e;
      logic [N-1:0] d;
      e = (i == 0) ? ena0 : ena1;
      d = (i == 0) ? duty0 : duty1;
      if (rst) begin
        m_run[i] = 1'b0;
        m_t[i]   = 0;
        m_dq[i]  = 0;
      end else if (!m_run[i]) begin
        if (e) begin
          m_run[i] = 1'b1;
          m_t[i]   = 0;
          m_dq[i]  = d;
        end
      end else if (!e) begin
        m_run[i] = 1'b0;
      end else begin
        m_t[i]++;
        if ((m_t[i] % plen(i)) == 0) m_dq[i] = d;
      end
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out%0d_t%0d", i, m_t[i]), get_out(i), exp_out(i));
      check($sformatf("pd%0d_t%0d", i, m_t[i]), get_pd(i), exp_pd(i));
    end
  endtask

  // One clock: model update on the edge, compare 1 time unit later, then drive loop feedback.
  task automatic step();
    logic pd_prev;
    pd_prev = pd1;
    @(posedge clk);
    model_edge();
    if (loop_on && pd_prev) begin
      if (tri_up) begin
        if (tri_v == NS - 1) begin tri_up = 1'b0; tri_v--; end
        else tri_v++;
      end else begin
        if (tri_v == 0) begin tri_up = 1'b1; tri_v++; end
        else tri_v--;
      end
    end
    #1;
    check_outs();
    if (loop_on) duty1 = N'(tri_v);
  endtask

  task automatic wait_pd(input int i);
    int k;
    k = 0;
    while (!get_pd(i) && k < 4 * int'(plen(i))) begin
      step();
      k++;
    end
    check($sformatf("wait_pd%0d", i), get_pd(i), 1);
  endtask

  // Counts high cycles over one period starting with the current cycle.
  task automatic count_hi(input int i, output int hi);
    hi = get_out(i);
    for (int k = 1; k < int'(plen(i)); k++) begin
      step();
      hi += get_out(i);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hi, prev, dlt;
    model_reset();

    #12;
    check("rst_out0", out0, 0);
    check("rst_pd0", pd0, 0);
    check("rst_out1", out1, 0);
    check("rst_pd1", pd1, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();

    // Nominal duty and shadowing on the PRESCALE=2 instance
    duty0 = 4'd5;
    ena0  = 1'b1;
    wait_pd(0);
    count_hi(0, hi);
    check("t1_high", hi, 10);
    step();
    check("t1_pd", pd0, 1);
    check("t1_out_rise", out0, 1);
    hi = out0;
    for (int k = 1; k < 32; k++) begin
      step();
      if (k == 7) duty0 = 4'd12;
      hi += out0;
    end
    check("t2_cur_high", hi, 10);
    step();
    check("t2_pd", pd0, 1);
    count_hi(0, hi);
    check("t2_new_high", hi, 24);

    // Duty extremes on the PRESCALE=1 instance
    duty1 = 4'd0;
    ena1  = 1'b1;
    wait_pd(1);
    count_hi(1, hi);
    check("t3_zero_high", hi, 0);
    duty1 = 4'd15;
    step();
    check("t3_pd", pd1, 1);
    count_hi(1, hi);
    check("t3_max_high", hi, 15);

    // Enable drop mid-period with cnt=3, then re-enable with new duty
    duty1 = 4'd10;
    step();
    check("t4_pd", pd1, 1);
    repeat (3) step();
    check("t4_out_before", out1, 1);
    ena1 = 1'b0;
    step();
    check("t4_out_off", out1, 0);
    check("t4_pd_off", pd1, 0);
    duty1 = 4'd7;
    ena1  = 1'b1;
    step();
    count_hi(1, hi);
    check("t4_restart_high", hi, 7);
    step();
    check("t4_restart_pd", pd1, 1);

    // ena falling exactly on the wrap edge: no strobe
    repeat (15) step();
    duty1 = 4'd9;
    ena1  = 1'b0;
    step();
    check("t4b_no_pd", pd1, 0);
    check("t4b_out", out1, 0);
    ena1 = 1'b1;
    step();
    check("t4b_reentry_out", out1, 1);

    // Asynchronous reset between edges
    repeat (5) step();
    #3;
    rst = 1'b1;
    #1;
    check("t5_out0", out0, 0);
    check("t5_pd0", pd0, 0);
    check("t5_out1", out1, 0);
    check("t5_pd1", pd1, 0);
    model_reset();
    #10;
    duty0 = 4'd3;
    rst   = 1'b0;
    step();
    count_hi(0, hi);
    check("t5_high", hi, 6);
    step();
    check("t5_pd", pd0, 1);

    // Closed loop: triangle generator advanced by period_done
    tri_v   = 3;
    tri_up  = 1'b1;
    duty1   = 4'd3;
    loop_on = 1'b1;
    wait_pd(1);
    prev = 0;
    for (int p = 0; p < 20; p++) begin
      count_hi(1, hi);
      if (p >= 2) begin
        dlt = hi - prev;
        if (dlt < 0) dlt = -dlt;
        check($sformatf("t6_delta_p%0d", p), dlt, 1);
      end
      prev = hi;
      step();
    end
    loop_on = 1'b0;

    // Randomized duty changes and enable toggling
    for (int c = 0; c < 1500; c++) begin
      step();
      if ($urandom_range(7) == 0) duty0 = N'($urandom);
      if ($urandom_range(7) == 0) duty1 = N'($urandom);
      if (ena0) begin if ($urandom_range(39) == 0) ena0 = 1'b0; end
      else if ($urandom_range(3) == 0) ena0 = 1'b1;
      if (ena1) begin if ($urandom_range(39) == 0) ena1 = 1'b0; end
      else if ($urandom_range(3) == 0) ena1 = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_driver.md
# pwm_driver

PWM output stage for the LED "breathing" path. It consumes an N-bit duty value, typically the triangle wave output, and produces a single PWM bit. It also emits a one-cycle `period_done` strobe at the end of every PWM period; the strobe is meant to drive the upstream generator's `ena`, so the duty advances exactly once per period. The duty value is shadowed: it is sampled only at period boundaries, so a mid-period change never produces a runt pulse.

## Interface
- `N`, default 8: duty and PWM counter width. The period is 2^N steps.
- `PRESCALE`, default 1: clk cycles per PWM step. Must be >= 1. The internal prescaler is $clog2(PRESCALE) bits, minimum 1 bit.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ena`  in  1: run enable. Low means idle: output low, counters cleared.
- `duty`  in  N: requested duty, unsigned. Sampled only at load points.
- `out`  out  1: PWM output.
- `period_done`  out  1: registered strobe, one clk wide, at each period wrap.

## Operation
- State machine, two states:
  - IDLE: `out`=0, `period_done`=0, `cnt`=0, `pcnt`=0.
  - RUN: counting.
- IDLE -> RUN on a clk edge where `ena`=1. On that edge:
  - `duty_q`<=`duty`
  - `cnt`<=0
  - `pcnt`<=0
- RUN -> IDLE on any edge where `ena`=0. On that edge `cnt`, `pcnt` and `period_done` are cleared; `duty_q` holds.
- Prescaler:
  - `step` = RUN && `ena` && (`pcnt`==PRESCALE-1).
  - `pcnt` increments each RUN cycle and wraps to 0 on `step`.
  - With PRESCALE=1, `step`=1 every RUN cycle.
- Counter: on `step`, `cnt`<=`cnt`+1 modulo 2^N, so it wraps from 2^N-1 to 0.
- Wrap edge: a `step` with `cnt`==2^N-1. On this edge:
  - `duty_q`<=`duty` (shadow reload).
  - `period_done`<=1.
  - On every other edge `period_done`<=0.
- `out` is combinational from registers: `out` = (state==RUN) && (`cnt` < `duty_q`), unsigned compare at N bits.
  - `duty_q`=0 gives `out` never high.
  - `duty_q`=2^N-1 gives `out` high for 2^N-1 of 2^N steps. There is no 100% duty by design.
- Simultaneous events:
  - `ena` falling on a would-be wrap edge: IDLE wins. No `period_done` and no reload.
  - `duty` changing on the wrap edge: the value present at that edge is captured.

## Timing
- Reset values, applied asynchronously, immediately on `rst` high:
  - state=IDLE
  - `cnt`=0, `pcnt`=0, `duty_q`=0
  - `period_done`=0, `out`=0
- Release of `rst` is synchronous to `clk`. The first possible IDLE->RUN is the first rising edge with `rst`=0 and `ena`=1.
- Start latency:
  - `out` reflects `duty_q` in the same cycle RUN is entered, i.e. the cycle after the enabling edge.
  - `out` is high at start iff `duty`>0 at that edge.
- Period length: 2^N * PRESCALE clk cycles, measured between `period_done` pulses while `ena` stays high.
- High time per period: `duty_q` * PRESCALE clk cycles, starting at the beginning of each period (left-aligned).
- `period_done` is high in the first cycle of the new period, the same cycle `cnt`=0 with the new `duty_q`. It is not asserted on IDLE->RUN entry.
- Stop latency: `ena` low sampled at an edge drives `out`=0 in the cycle after that edge.
- `rst` mid-RUN: all outputs are 0 with no clock edge needed, and the next period starts fresh.

## Test plan
1. Nominal duty: N=4, PRESCALE=2, `duty`=5, `ena` held high.
   - Required: `out` high 10 clk then low 22 clk, repeating.
   - Required: `period_done` one clk wide every 32 clk, coincident with `out` rising.
2. Shadowing: `duty` changes 5 -> 12 at clk 7 of a period.
   - Required: the current period still shows 10 high cycles.
   - Required: from the cycle `period_done` is high, `out` shows 24 high / 8 low.
3. Duty extremes: N=4, PRESCALE=1.
   - `duty`=0: `out` never high, `period_done` every 16 clk.
   - `duty`=15: `out` high 15 / low 1.
4. Enable drop: `ena` falls mid-period with `cnt`=3, `out`=1.
   - Required: `out`=0 the next cycle and no `period_done`.
   - Required: on re-enable, `cnt` restarts at 0 and the new `duty` is loaded.
5. Async reset: assert `rst` mid-RUN between clock edges.
   - Required: `out`, `period_done` and internal state go to 0 immediately.
   - Required: after release, the full-period count is correct from the first `ena` edge.
6. Closed loop: N=4, PRESCALE=1, `period_done` wired to an upstream triangle counter's enable, its value fed to `duty`.
   - Required: `duty_q` changes by exactly ±1 per 16-clk period.
   - Required: `out` high count per period tracks the triangle value.
